// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the PLL enable/lock controller.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitLock,
    StLocked,
    StOff,
    StFail
  } pll_ctrl_state_e;

  // A zero divider is not a legal PLL setting; treat it as divide-by-one.
  function automatic logic [7:0] map_fbdiv(input logic [7:0] fbdiv);
    return (fbdiv == 8'd0) ? 8'd1 : fbdiv;
  endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Counts consecutive lock-low cycles; pulses lost when LOSS_FILTER of them are seen.
module pll_lock_filter #(
  parameter int unsigned LOSS_FILTER = 2
) (
  input  logic rclk,
  input  logic rst,
  input  logic clear,
  input  logic lock,
  output logic lost
);

  localparam int unsigned CW = $clog2(LOSS_FILTER + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    lost  = !clear && !lock && (cnt_q == CW'(LOSS_FILTER - 1));
    cnt_d = cnt_q;
    if (clear || lock || lost) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pll_ctrl.sv
// PLL enable sequencer: lock wait with timeout/retry, loss-of-lock filtering,
// and divider changes applied only while the PLL is disabled.
module pll_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned OFF_CYCLES   = 4,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned LOSS_FILTER  = 2
) (
  input  logic       rclk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] fbdiv_in,
  input  logic       lock,
  output logic       pll_en,
  output logic [7:0] pll_fbdiv,
  output logic       ready,
  output logic       fail,
  output logic       lost_lock,
  output logic [1:0] retry_cnt
);

  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned OW = $clog2(OFF_CYCLES + 1);
  localparam int unsigned RW = (MAX_RETRY < 3) ? 2 : $clog2(MAX_RETRY + 1);

  pll_ctrl_state_e state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [OW-1:0]   off_q, off_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [7:0]      fbdiv_q, fbdiv_d;
  logic            pll_en_q, ready_q, fail_q, lost_q, lost_d;
  logic            lost;

  pll_lock_filter #(
    .LOSS_FILTER (LOSS_FILTER)
  ) u_lock_filter (
    .rclk  (rclk),
    .rst   (rst),
    .clear (state_q != StLocked),
    .lock  (lock),
    .lost  (lost)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    off_d   = off_q;
    retry_d = retry_q;
    fbdiv_d = fbdiv_q;
    lost_d  = 1'b0;
    if (!req) begin
      state_d = StIdle;
      timer_d = '0;
      off_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StWaitLock;
          fbdiv_d = map_fbdiv(fbdiv_in);
          timer_d = '0;
          retry_d = '0;
        end
        StWaitLock: begin
          if (lock) begin
            state_d = StLocked;
            timer_d = '0;
          end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
            timer_d = '0;
            off_d   = '0;
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_d = retry_q + RW'(1);
              state_d = StOff;
            end else begin
              state_d = StFail;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        StLocked: begin
          if (lost) begin
            lost_d  = 1'b1;
            retry_d = '0;
            off_d   = '0;
            state_d = StOff;
          end else if (map_fbdiv(fbdiv_in) != fbdiv_q) begin
            off_d   = '0;
            state_d = StOff;
          end
        end
        StOff: begin
          if (off_q == OW'(OFF_CYCLES - 1)) begin
            state_d = StWaitLock;
            fbdiv_d = map_fbdiv(fbdiv_in);
            timer_d = '0;
            off_d   = '0;
          end else begin
            off_d = off_q + OW'(1);
          end
        end
        StFail:  ;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      off_q    <= '0;
      retry_q  <= '0;
      fbdiv_q  <= 8'd1;
      pll_en_q <= 1'b0;
      ready_q  <= 1'b0;
      fail_q   <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      off_q    <= off_d;
      retry_q  <= retry_d;
      fbdiv_q  <= fbdiv_d;
      pll_en_q <= (state_d == StWaitLock) || (state_d == StLocked);
      ready_q  <= (state_d == StLocked);
      fail_q   <= (state_d == StFail);
      lost_q   <= lost_d;
    end
  end

  assign pll_en    = pll_en_q;
  assign pll_fbdiv = fbdiv_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign lost_lock = lost_q;
  assign retry_cnt = (retry_q > RW'(3)) ? 2'd3 : retry_q[1:0];

endmodule

// File: tb/tb_pll_ctrl.sv
// Directed bench for pll_ctrl: vector table plus multi-cycle sequences.
module tb_pll_ctrl;

  logic       rclk = 1'b0;
  logic       rst  = 1'b1;
  logic       req  = 1'b0;
  logic [7:0] fbdiv_in = 8'd8;
  logic       lock = 1'b0;
  logic       pll_en, ready, fail, lost_lock;
  logic [7:0] pll_fbdiv;
  logic [1:0] retry_cnt;

  logic       req_b  = 1'b0;
  logic       lock_b = 1'b0;
  logic       pll_en_b, ready_b, fail_b, lost_lock_b;
  logic [7:0] pll_fbdiv_b;
  logic [1:0] retry_cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 rclk = ~rclk;

  pll_ctrl #(
    .LOCK_TIMEOUT (128),
    .OFF_CYCLES   (4),
    .MAX_RETRY    (3),
    .LOSS_FILTER  (2)
  ) dut (
    .rclk      (rclk),
    .rst       (rst),
    .req       (req),
    .fbdiv_in  (fbdiv_in),
    .lock      (lock),
    .pll_en    (pll_en),
    .pll_fbdiv (pll_fbdiv),
    .ready     (ready),
    .fail      (fail),
    .lost_lock (lost_lock),
    .retry_cnt (retry_cnt)
  );

  pll_ctrl #(
    .LOCK_TIMEOUT (16),
    .OFF_CYCLES   (4),
    .MAX_RETRY    (3),
    .LOSS_FILTER  (2)
  ) dut_b (
    .rclk      (rclk),
    .rst       (rst),
    .req       (req_b),
    .fbdiv_in  (8'd8),
    .lock      (lock_b),
    .pll_en    (pll_en_b),
    .pll_fbdiv (pll_fbdiv_b),
    .ready     (ready_b),
    .fail      (fail_b),
    .lost_lock (lost_lock_b),
    .retry_cnt (retry_cnt_b)
  );

  typedef struct {
    logic       req;
    logic [7:0] fb;
    logic       lock;
    logic       en;
    logic       rdy;
    logic       fl;
    logic       lost;
    logic [7:0] efb;
    logic [1:0] rc;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic en, input logic rdy, input logic fl,
                       input logic lost, input logic [7:0] fb, input logic [1:0] rc);
    chk({tag, ".pll_en"}, pll_en, en);
    chk({tag, ".ready"}, ready, rdy);
    chk({tag, ".fail"}, fail, fl);
    chk({tag, ".lost_lock"}, lost_lock, lost);
    chk({tag, ".pll_fbdiv"}, pll_fbdiv, fb);
    chk({tag, ".retry_cnt"}, retry_cnt, rc);
  endtask

  initial begin
    //          req  fb     lock  en    rdy   fail  lost  efb    rc
    vecs[0]  = '{1'b0, 8'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1,  2'd0};
    vecs[1]  = '{1'b1, 8'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5,  2'd0};
    vecs[2]  = '{1'b1, 8'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5,  2'd0};
    vecs[3]  = '{1'b1, 8'd5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5,  2'd0};
    vecs[4]  = '{1'b1, 8'd5,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5,  2'd0};
    vecs[5]  = '{1'b1, 8'd5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5,  2'd0};
    vecs[6]  = '{1'b1, 8'd5,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5,  2'd0};
    vecs[7]  = '{1'b1, 8'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5,  2'd0};
    vecs[8]  = '{1'b1, 8'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5,  2'd0};
    vecs[9]  = '{1'b1, 8'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5,  2'd0};
    vecs[10] = '{1'b1, 8'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5,  2'd0};
    vecs[11] = '{1'b1, 8'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1,  2'd0};
    vecs[12] = '{1'b1, 8'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1,  2'd0};
    vecs[13] = '{1'b1, 8'd16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1,  2'd0};
    vecs[14] = '{1'b1, 8'd16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1,  2'd0};
    vecs[15] = '{1'b1, 8'd16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1,  2'd0};
    vecs[16] = '{1'b1, 8'd16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1,  2'd0};
    vecs[17] = '{1'b1, 8'd16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd16, 2'd0};
    vecs[18] = '{1'b1, 8'd16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd16, 2'd0};
    vecs[19] = '{1'b0, 8'd16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd16, 2'd0};

    // Reset values, held across edges.
    step();
    step();
    chk_a("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 2'd0);
    chk("reset.b.pll_en", pll_en_b, 1'b0);

    // No transition after release until req is seen.
    rst = 1'b0;
    step();
    step();
    chk_a("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 2'd0);

    for (int i = 0; i < 20; i++) begin
      req      = vecs[i].req;
      fbdiv_in = vecs[i].fb;
      lock     = vecs[i].lock;
      step();
      chk_a($sformatf("vec%0d", i), vecs[i].en, vecs[i].rdy, vecs[i].fl, vecs[i].lost,
            vecs[i].efb, vecs[i].rc);
    end

    // Lock arriving 100 cycles after the request, then a divider change while locked.
    req = 1'b1; fbdiv_in = 8'd8; lock = 1'b0;
    step();
    chk_a("slow_lock.start", 1'b1, 1'b0, 1'b0, 1'b0, 8'd8, 2'd0);
    for (int i = 1; i < 100; i++) step();
    chk_a("slow_lock.waiting", 1'b1, 1'b0, 1'b0, 1'b0, 8'd8, 2'd0);
    lock = 1'b1;
    step();
    chk_a("slow_lock.locked", 1'b1, 1'b1, 1'b0, 1'b0, 8'd8, 2'd0);
    fbdiv_in = 8'd16;
    step();
    chk_a("fbdiv_change.off0", 1'b0, 1'b0, 1'b0, 1'b0, 8'd8, 2'd0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_a($sformatf("fbdiv_change.off%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 8'd8, 2'd0);
    end
    step();
    chk_a("fbdiv_change.reenable", 1'b1, 1'b0, 1'b0, 1'b0, 8'd16, 2'd0);
    req = 1'b0;
    step();

    // Timeout/retry on the short-timeout instance: 20-cycle attempt period, fail after 4th.
    req_b = 1'b1;
    for (int k = 0; k < 86; k++) begin
      logic       e_en;
      logic [1:0] e_rc;
      step();
      e_en = (k < 76) && ((k % 20) < 16);
      e_rc = (k < 16) ? 2'd0 : (k < 36) ? 2'd1 : (k < 56) ? 2'd2 : 2'd3;
      chk($sformatf("timeout.k%0d.pll_en", k), pll_en_b, e_en);
      chk($sformatf("timeout.k%0d.fail", k), fail_b, (k >= 76));
      chk($sformatf("timeout.k%0d.retry_cnt", k), retry_cnt_b, e_rc);
    end
    req_b = 1'b0;
    step();
    chk("fail_exit.fail", fail_b, 1'b0);
    chk("fail_exit.pll_en", pll_en_b, 1'b0);
    chk("fail_exit.retry_cnt", retry_cnt_b, 2'd0);
    chk("fail_exit.ready", ready_b, 1'b0);
    chk("fail_exit.lost_lock", lost_lock_b, 1'b0);

    // Reset mid-attempt must drop pll_en before the next edge.
    req = 1'b1; fbdiv_in = 8'd3; lock = 1'b0;
    step();
    chk_a("rst_mid.wait", 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 2'd0);
    #3;
    rst = 1'b1;
    #1;
    chk_a("rst_mid.async", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 2'd0);
    step();
    chk_a("rst_mid.held", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 2'd0);
    req = 1'b0;
    rst = 1'b0;
    step();
    chk_a("rst_mid.released", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 2'd0);
    req = 1'b1;
    step();
    chk_a("rst_mid.restart", 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 2'd0);
    req = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_ctrl.md
PLL_CTRL -- requirements
Module: pll_ctrl

Interface
REQ-001 Parameter LOCK_TIMEOUT, default 4096, rclk cycles allowed per lock attempt (>=2).
REQ-002 Parameter OFF_CYCLES, default 4, minimum rclk cycles pll_en held low between attempts (>=1).
REQ-003 Parameter MAX_RETRY, default 3, retries allowed after the first attempt times out.
REQ-004 Parameter LOSS_FILTER, default 2, consecutive lock-low cycles that constitute loss of lock (>=1).
REQ-005 rclk  input  1  sole clock; all logic on posedge rclk.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 req  input  1  level request: 1 = PLL wanted running.
REQ-008 fbdiv_in  input  8  requested feedback divider.
REQ-009 lock  input  1  PLL lock indication, synchronous to rclk.
REQ-010 pll_en  output  1  PLL enable.
REQ-011 pll_fbdiv  output  8  divider applied to the PLL, registered.
REQ-012 ready  output  1  high only while in LOCKED.
REQ-013 fail  output  1  high only while in FAIL.
REQ-014 lost_lock  output  1  single-cycle pulse on declared loss of lock.
REQ-015 retry_cnt  output  2  attempts consumed in the current request, saturating at 3.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_LOCK, LOCKED, OFF, FAIL; all outputs registered.
REQ-017 req=0 in any state SHALL force IDLE on the next edge, overriding all other transitions.
REQ-018 IDLE: pll_en=0; on req=1, latch fbdiv_in into pll_fbdiv (0 mapped to 1), clear timer and retry count, go WAIT_LOCK.
REQ-019 WAIT_LOCK: pll_en=1; timer increments each cycle; lock=1 moves to LOCKED.
REQ-020 WAIT_LOCK timer reaching LOCK_TIMEOUT-1 without lock: retry_cnt<MAX_RETRY increments retry_cnt and goes OFF; otherwise goes FAIL.
REQ-021 Lock and timeout in the same cycle: lock wins.
REQ-022 LOCKED: pll_en=1, ready=1; LOSS_FILTER consecutive lock=0 cycles assert lost_lock for one cycle, clear retry_cnt, go OFF.
REQ-023 LOCKED: fbdiv_in differing from pll_fbdiv (after 0->1 mapping) goes OFF without lost_lock.
REQ-024 OFF: pll_en=0 for exactly OFF_CYCLES cycles; on exit, re-latch fbdiv_in into pll_fbdiv, clear timer, go WAIT_LOCK.
REQ-025 pll_fbdiv SHALL change only on IDLE->WAIT_LOCK or OFF->WAIT_LOCK, never while pll_en=1.
REQ-026 FAIL: pll_en=0, fail=1; held until req=0.
REQ-027 Timer width SHALL be $clog2(LOCK_TIMEOUT+1); no counter wraps.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, pll_en=0, pll_fbdiv=1, ready=0, fail=0, lost_lock=0, retry_cnt=0, timers cleared.
REQ-029 After rst release, the first transition SHALL occur no earlier than the first rclk edge with req=1.
REQ-030 rst mid-attempt SHALL drop pll_en asynchronously, not at the next edge.

Structure
REQ-031 State enum pll_ctrl_state_e and the fbdiv 0->1 mapping function SHALL live in package pll_ctrl_pkg.
REQ-032 The lock-loss filter SHALL be sub-module pll_lock_filter (rclk, rst, clear, lock -> lost pulse).

Verification
REQ-033 req=1, fbdiv_in=8, lock rises 100 cycles later -> pll_en=1 next cycle, ready=1 one cycle after lock, retry_cnt=0.
REQ-034 LOCK_TIMEOUT=16, MAX_RETRY=3, lock tied 0 -> three OFF windows of 4 cycles each, fail=1 after the 4th timeout, pll_en=0.
REQ-035 Locked, lock low 1 cycle then 2 cycles (LOSS_FILTER=2) -> no pulse, then one lost_lock pulse, pll_en low 4 cycles.
REQ-036 Locked with fbdiv 8, fbdiv_in changed to 16 -> OFF 4 cycles, pll_fbdiv=16 on re-enable, lost_lock stays 0.
REQ-037 fbdiv_in=0 -> pll_fbdiv=1.
REQ-038 rst pulse mid-WAIT_LOCK and req drop in FAIL -> outputs at reset values; FAIL exits to IDLE next edge.
